// File: rtl/bch_pkg.sv
// Shared BCH(31,16) constants and encoder FSM state type, also used by the decoder-side blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bch_pkg;

    localparam int BCH_N = 31;
    localparam int BCH_K = 16;
    localparam int BCH_M = 5;

    // g(x) = x^15+x^11+x^10+x^9+x^8+x^7+x^5+x^3+x^2+x+1, bit i = coeff of x^i
    localparam logic [15:0] BCH_G_POLY = 16'h8FAF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } bch_state_e;

endpackage

// File: rtl/bch_lfsr_div.sv
// Serial GF(2) polynomial divider: remainder of (bit stream * x^W) mod g(x), MSB first.
// Latency: one input bit absorbed per enabled cycle; remainder is registered.
// Backpressure: none; the caller gates progress with en_i.
module bch_lfsr_div #(
    parameter int           W    = 15,
    parameter logic [W-1:0] POLY = 15'h0FAF   // g(x) without its leading x^W term
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] rem_o
);

    logic [W-1:0] rem_q;
    logic [W-1:0] rem_d;
    logic         fb;

    // Next remainder: shift in a zero and fold g(x) back in when the feedback bit is set.
    always_comb begin
        fb    = bit_i ^ rem_q[W-1];
        rem_d = {rem_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    // Remainder register; clear wins over enable so a new message always starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
        end else if (clr_i) begin
            rem_q <= '0;
        end else if (en_i) begin
            rem_q <= rem_d;
        end
    end

    assign rem_o = rem_q;

endmodule

// File: rtl/bch_encoder.sv
// Systematic BCH(31,16) encoder: codeword = {msg, msg*x^15 mod g(x)}; optional BCH_ENC_ERR_INJECT_EN XORs a latched err_mask.
// Latency: 17 cycles from the accept cycle to cw_valid; one codeword per K+2 cycles at best.
// Backpressure: msg_ready low outside IDLE; cw_valid/codeword hold until cw_ready.
module bch_encoder
    import bch_pkg::*;
#(
    parameter int             N      = BCH_N,
    parameter int             K      = BCH_K,
    parameter logic [N-K:0]   G_POLY = BCH_G_POLY
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [K-1:0] msg,
    output logic         cw_valid,
    input  logic         cw_ready,
    output logic [N-1:0] codeword,
`ifdef BCH_ENC_ERR_INJECT_EN
    input  logic [N-1:0] err_mask,
`endif
    output logic         busy
);

    localparam int R  = N - K;
    localparam int CW = $clog2(K);

    bch_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [K-1:0]   shreg_q, shreg_d;   // working copy, consumed MSB first
    logic [K-1:0]   msg_q, msg_d;       // untouched copy for the systematic part
    logic           lfsr_clr;
    logic           lfsr_en;
    logic [R-1:0]   parity;
`ifdef BCH_ENC_ERR_INJECT_EN
    logic [N-1:0]   err_q, err_d;
`endif

    bch_lfsr_div #(
        .W    (R),
        .POLY (G_POLY[R-1:0])
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (lfsr_clr),
        .en_i    (lfsr_en),
        .bit_i   (shreg_q[K-1]),
        .rem_o   (parity)
    );

    // Next-state and datapath control for accept / shift / present.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        msg_d    = msg_q;
        lfsr_clr = 1'b0;
        lfsr_en  = 1'b0;
`ifdef BCH_ENC_ERR_INJECT_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (msg_valid) begin
                    shreg_d  = msg;
                    msg_d    = msg;
                    cnt_d    = '0;
                    lfsr_clr = 1'b1;
`ifdef BCH_ENC_ERR_INJECT_EN
                    err_d    = err_mask;
`endif
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_en = 1'b1;
                shreg_d = {shreg_q[K-2:0], 1'b0};
                if (cnt_q == CW'(K - 1)) begin
                    // Last bit: park the counter instead of letting it roll over.
                    cnt_d   = '0;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (cw_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight message.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            msg_q   <= '0;
`ifdef BCH_ENC_ERR_INJECT_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            msg_q   <= msg_d;
`ifdef BCH_ENC_ERR_INJECT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs are pure decodes of registers, so no input reaches an output combinationally.
    assign msg_ready = (state_q == IDLE);
    assign cw_valid  = (state_q == OUT);
    assign busy      = (state_q != IDLE);
`ifdef BCH_ENC_ERR_INJECT_EN
    assign codeword  = {msg_q, parity} ^ err_q;
`else
    assign codeword  = {msg_q, parity};
`endif

endmodule

// File: tb/tb_bch_encoder.sv
// Scoreboarded bench for bch_encoder: directed vectors, stall, mid-shift reset, random traffic.
// Latency: expects cw_valid 17 cycles after the accept cycle.
// Backpressure: drives cw_ready high, held low, or random.
module tb_bch_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        msg_valid = 1'b0;
    logic [15:0] msg = '0;
    logic        cw_ready = 1'b0;
    logic        msg_ready;
    logic        cw_valid;
    logic [30:0] codeword;
    logic        busy;
`ifdef BCH_ENC_ERR_INJECT_EN
    logic [30:0] err_mask = '0;
`endif

    bch_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg       (msg),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .codeword  (codeword),
`ifdef BCH_ENC_ERR_INJECT_EN
        .err_mask  (err_mask),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [30:0] exp_q[$];
    int          acc_q[$];

    bit hold_low = 1'b0;
    bit rand_rdy = 1'b0;

    // Reference: long division of m(x)*x^15 by g(x), done on the whole polynomial.
    function automatic logic [14:0] ref_parity(input logic [15:0] m);
        logic [30:0] r;
        logic [30:0] g;
        r = {m, 15'b0};
        g = 31'h0000_8FAF;
        for (int i = 30; i >= 15; i--) begin
            if (r[i]) r = r ^ (g << (i - 15));
        end
        return r[14:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Offer a message; garbage is driven on msg while the encoder is not ready.
    task automatic send_exp(input logic [15:0] m, input logic [30:0] e, input logic [30:0] exp_cw);
        int  waited;
        bit  done;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (reset_n && msg_ready) begin
                msg       = m;
                msg_valid = 1'b1;
`ifdef BCH_ENC_ERR_INJECT_EN
                err_mask  = e;
`endif
                exp_q.push_back(exp_cw);
                acc_q.push_back(cyc);
                chk("no_cw_valid_at_accept", {63'b0, cw_valid}, 64'd0);
                done = 1'b1;
            end else begin
                msg       = 16'($urandom);
                msg_valid = 1'b1;
`ifdef BCH_ENC_ERR_INJECT_EN
                err_mask  = 31'($urandom);
`endif
                waited++;
                if (waited > 200) begin
                    fail_now("send_timeout");
                    msg_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        msg       = 16'($urandom);
    endtask

    task automatic send(input logic [15:0] m, input logic [30:0] e);
        logic [30:0] x;
        x = {m, ref_parity(m)};
`ifdef BCH_ENC_ERR_INJECT_EN
        x = x ^ e;
`endif
        send_exp(m, e, x);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() > 0) fail_now("drain_timeout");
        @(posedge clk);
    endtask

    // cw_ready driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_low)      cw_ready = 1'b0;
            else if (rand_rdy) cw_ready = 1'($urandom_range(0, 1));
            else               cw_ready = 1'b1;
        end
    end

    // Monitor: latency on each cw_valid rise, stability under stall, codeword on handshake.
    initial begin
        bit          prev_vld;
        bit          prev_rdy;
        logic [30:0] prev_cw;
        prev_vld = 1'b0;
        prev_rdy = 1'b0;
        prev_cw  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_vld = 1'b0;
            end else begin
                if (cw_valid && !prev_vld) begin
                    if (acc_q.size() == 0) fail_now("unexpected_cw_valid");
                    else chk("latency", 64'(cyc - acc_q.pop_front()), 64'd17);
                end
                if (cw_valid) begin
                    chk("msg_ready_in_out", {63'b0, msg_ready}, 64'd0);
                    chk("busy_in_out", {63'b0, busy}, 64'd1);
                    if (prev_vld && !prev_rdy) chk("stall_stable", {33'b0, codeword}, {33'b0, prev_cw});
                end
                if (cw_valid && cw_ready) begin
                    if (exp_q.size() == 0) fail_now("codeword_without_expectation");
                    else chk("codeword", {33'b0, codeword}, {33'b0, exp_q.pop_front()});
                end
                prev_vld = cw_valid;
                prev_rdy = cw_ready;
                prev_cw  = codeword;
            end
        end
    end

    initial begin
        int t;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_msg_ready", {63'b0, msg_ready}, 64'd1);
        chk("rst_cw_valid",  {63'b0, cw_valid},  64'd0);
        chk("rst_busy",      {63'b0, busy},      64'd0);
        chk("rst_codeword",  {33'b0, codeword},  64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed vectors from the generator polynomial.
        send_exp(16'h0000, 31'h0, 31'h0);
        send_exp(16'h0001, 31'h0, {16'h0001, 15'h0FAF});
        send_exp(16'h0002, 31'h0, {16'h0002, 15'h1F5E});
        send_exp(16'h0003, 31'h0, {16'h0003, 15'h10F1});
`ifdef BCH_ENC_ERR_INJECT_EN
        send_exp(16'h0001, 31'h1, {16'h0001, 15'h0FAE});
`endif
        drain();

        // Output stall with the next message pending.
        hold_low = 1'b1;
        send(16'hA5C3, 31'h0);
        fork
            send(16'h5A3C, 31'h0);
            begin
                t = 0;
                while (!cw_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                if (!cw_valid) fail_now("stall_no_cw_valid");
                repeat (10) @(posedge clk);
                #2;
                chk("stall_cw_valid_held", {63'b0, cw_valid},  64'd1);
                chk("stall_msg_ready_low", {63'b0, msg_ready}, 64'd0);
                hold_low = 1'b0;
            end
        join
        drain();

        // Reset in the middle of shifting.
        send(16'h1234, 31'h0);
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("midrst_msg_ready", {63'b0, msg_ready}, 64'd1);
        chk("midrst_cw_valid",  {63'b0, cw_valid},  64'd0);
        chk("midrst_busy",      {63'b0, busy},      64'd0);
        chk("midrst_codeword",  {33'b0, codeword},  64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_cw_valid", {63'b0, cw_valid}, 64'd0);
        send_exp(16'h0001, 31'h0, {16'h0001, 15'h0FAF});
        drain();

        // Random traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(16'($urandom), 31'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();
        rand_rdy = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
